// File: rtl/ov7670_fb_ctrl.sv
// ov7670_fb_ctrl -- frame-buffer sequencer for the 1-bit camera frame RAM.
//
// Write side: turns the binarised OV7670 pixel stream into RAM writes with
// linear addresses. A Start pulse arms capture of the next frame. Capture
// begins on a VSYNC rising edge and ends after V_ACTIVE lines, or earlier on
// the next VSYNC rising edge, which also sets ShortFrame.
// Read side: (RdX,RdY) requests are answered two cycles later on RdValid/RdData.
// The read side runs independently of the capture state.
//
// Ports:
//   Clock, Reset            rising-edge clock; asynchronous active-high reset
//   Start                   arms capture (ignored while Busy)
//   Busy, FrameDone         capture in progress; one-cycle end-of-capture pulse
//   ShortFrame              sticky: last capture was cut short by VSYNC
//   CamVsync, CamHref       camera sync inputs
//   CamPixValid, CamPix     pixel strobe (qualified by CamHref) and pixel bit
//   RdReq, RdX, RdY         read request and coordinates
//   RdValid, RdData         read response, two cycles after RdReq
//   RamWE/RamWAddr/RamDIn   RAM write port
//   RamRAddr/RamDOut        RAM read port (one-cycle registered read data)
//
// Build option: define OV7670_FB_CONTINUOUS_EN for continuous capture. DONE
// then re-arms for the next frame, and a Start pulse while Busy stops capture
// after the current frame.

module ov7670_fb_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int AW       = 19,
   parameter int XW       = 10,
   parameter int YW       = 9
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Start,
   output logic          Busy,
   output logic          FrameDone,
   output logic          ShortFrame,
   input  logic          CamVsync,
   input  logic          CamHref,
   input  logic          CamPixValid,
   input  logic          CamPix,
   input  logic          RdReq,
   input  logic [XW-1:0] RdX,
   input  logic [YW-1:0] RdY,
   output logic          RdValid,
   output logic          RdData,
   output logic          RamWE,
   output logic [AW-1:0] RamWAddr,
   output logic          RamDIn,
   output logic [AW-1:0] RamRAddr,
   input  logic          RamDOut
);

   localparam int CW = $clog2(H_ACTIVE + 1);
   localparam int RW = $clog2(V_ACTIVE + 1);
   localparam logic [CW-1:0] COL_MAX   = CW'(H_ACTIVE);
   localparam logic [RW-1:0] ROW_MAX   = RW'(V_ACTIVE);
   localparam logic [RW-1:0] ROW_LAST  = RW'(V_ACTIVE - 1);
   localparam logic [AW-1:0] LINE_STEP = AW'(H_ACTIVE);
   localparam logic [XW:0]   X_LIM     = (XW+1)'(H_ACTIVE);
   localparam logic [YW:0]   Y_LIM     = (YW+1)'(V_ACTIVE);

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

   state_t        state, stateNext;
   logic          vsyncQ, vsyncPrev, hrefQ, hrefPrev;
   logic          vsyncRise, hrefFall;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [AW-1:0] lineBase;
   logic          pixStrobe, rowDone, shortExit, startAccept, pixWrite;
   logic          rdInRange, rdReqQ, rdOkQ, rdOk2;
   logic [AW-1:0] rdAddr;
`ifdef OV7670_FB_CONTINUOUS_EN
   logic          stopReq;
`endif

   // Sync inputs are registered once. Edges are taken between that copy and
   // the copy one cycle older.
   // NOTE: every clocked block uses non-blocking (<=) assignments, so each
   // register samples the values from before the edge regardless of the
   // order in which the blocks are evaluated.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         vsyncQ    <= 1'b0;
         vsyncPrev <= 1'b0;
         hrefQ     <= 1'b0;
         hrefPrev  <= 1'b0;
      end else begin
         vsyncQ    <= CamVsync;
         vsyncPrev <= vsyncQ;
         hrefQ     <= CamHref;
         hrefPrev  <= hrefQ;
      end
   end

   assign vsyncRise = vsyncQ & ~vsyncPrev;
   assign hrefFall  = ~hrefQ & hrefPrev;
   assign pixStrobe = CamHref & CamPixValid;

   // The line counter reaches V_ACTIVE either already, or on this cycle's
   // HREF fall. Either way it takes priority over a concurrent VSYNC edge.
   assign rowDone = (row == ROW_MAX) || (hrefFall && (row == ROW_LAST));

   // NOTE: every output of this block gets a default before the case
   // statement. Without that, a path that skips an assignment would infer a latch.
   always_comb begin
      stateNext   = state;
      startAccept = 1'b0;
      shortExit   = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               stateNext   = ARM;
               startAccept = 1'b1;
            end
         end
         ARM: begin
            if (vsyncRise) stateNext = CAPTURE;
         end
         CAPTURE: begin
            if (rowDone) begin
               stateNext = DONE;
            end else if (vsyncRise) begin
               stateNext = DONE;
               shortExit = 1'b1;
            end
         end
         DONE: begin
`ifdef OV7670_FB_CONTINUOUS_EN
            stateNext = stopReq ? IDLE : ARM;
`else
            stateNext = IDLE;
`endif
         end
         default: stateNext = IDLE;
      endcase
   end

   // Pixels beyond H_ACTIVE are dropped. No write happens in the cycle that
   // ends a line or the frame.
   assign pixWrite = (state == CAPTURE) && pixStrobe && (col < COL_MAX) &&
                     !rowDone && !vsyncRise && !hrefFall;

   assign FrameDone = (state == DONE);
`ifdef OV7670_FB_CONTINUOUS_EN
   assign Busy = (state != IDLE) && !((state == DONE) && stopReq);
`else
   assign Busy = (state == ARM) || (state == CAPTURE);
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         ShortFrame <= 1'b0;
      end else begin
         state <= stateNext;
         if (startAccept)    ShortFrame <= 1'b0;
         else if (shortExit) ShortFrame <= 1'b1;
      end
   end

`ifdef OV7670_FB_CONTINUOUS_EN
   // A Start pulse while Busy requests a stop at the end of the current frame.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                                   stopReq <= 1'b0;
      else if (startAccept || (state == DONE && stopReq)) stopReq <= 1'b0;
      else if (Start && Busy)                      stopReq <= 1'b1;
   end
`endif

   // Counters hold at zero outside CAPTURE, so every capture starts at
   // address 0. The line base grows by H_ACTIVE on each HREF fall, which
   // avoids a multiplier on the write side.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         col      <= '0;
         row      <= '0;
         lineBase <= '0;
      end else if (state != CAPTURE) begin
         col      <= '0;
         row      <= '0;
         lineBase <= '0;
      end else if (hrefFall) begin
         col      <= '0;
         row      <= row + RW'(1);
         lineBase <= lineBase + LINE_STEP;
      end else if (pixWrite) begin
         col <= col + CW'(1);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         RamWE    <= 1'b0;
         RamWAddr <= '0;
         RamDIn   <= 1'b0;
      end else begin
         RamWE <= pixWrite;
         if (pixWrite) begin
            RamWAddr <= lineBase + AW'(col);
            RamDIn   <= CamPix;
         end
      end
   end

   // Read pipeline. Out-of-range requests still return RdValid but leave
   // RamRAddr unchanged and force RdData to 0.
   assign rdInRange = ({1'b0, RdX} < X_LIM) && ({1'b0, RdY} < Y_LIM);
   assign rdAddr    = AW'(RdY) * LINE_STEP + AW'(RdX);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rdReqQ   <= 1'b0;
         rdOkQ    <= 1'b0;
         rdOk2    <= 1'b0;
         RdValid  <= 1'b0;
         RamRAddr <= '0;
      end else begin
         rdReqQ  <= RdReq;
         rdOkQ   <= RdReq & rdInRange;
         RdValid <= rdReqQ;
         rdOk2   <= rdOkQ;
         if (RdReq && rdInRange) RamRAddr <= rdAddr;
      end
   end

   assign RdData = RdValid & rdOk2 & RamDOut;

endmodule

// File: doc/ov7670_fb_ctrl.md
Name: ov7670_fb_ctrl

Overview:
- Sequences the 1-bit 640x480 camera frame RAM.
- Write side: converts the OV7670 binarised pixel stream (VSYNC/HREF/pixel-valid) into RAM write enables and linear addresses, with single-shot frame capture under a Start/Done handshake.
- Read side: serves display/processing (X,Y) read requests with a fixed 2-cycle latency.
- Sits between the camera capture front-end, the frame RAM, and the VGA/consumer logic.

Parameters:
- H_ACTIVE, 640: pixels per line.
- V_ACTIVE, 480: lines per frame.
- AW, 19: RAM address width; must satisfy 2^AW >= H_ACTIVE*V_ACTIVE.
- XW, 10: read X coordinate width.
- YW, 9: read Y coordinate width.

Ports:
- Clock  in  1  system clock; all logic is rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse that arms capture of the next frame.
- Busy  out  1  high from Start accepted until frame done.
- FrameDone  out  1  one-cycle pulse when capture ends.
- ShortFrame  out  1  sticky flag: last capture ended early on VSYNC; cleared by Start.
- CamVsync  in  1  camera VSYNC, active high.
- CamHref  in  1  camera HREF, high during active line.
- CamPixValid  in  1  one-cycle strobe per pixel, qualified by CamHref.
- CamPix  in  1  binarised pixel value.
- RdReq  in  1  read request strobe.
- RdX  in  XW  read column.
- RdY  in  YW  read row.
- RdValid  out  1  read data valid.
- RdData  out  1  pixel read back.
- RamWE  out  1  RAM write enable.
- RamWAddr  out  AW  RAM write address.
- RamDIn  out  1  RAM write data.
- RamRAddr  out  AW  RAM read address.
- RamDOut  in  1  RAM read data; one-cycle registered latency.

Behaviour:
- Reset (asynchronous; takes effect mid-frame too): state IDLE, all outputs 0, all counters 0. RamWE drops immediately and no partial write is issued after reset.
- VSYNC and HREF are registered once internally. Edges are detected on the registered copies.
- IDLE:
  - Start -> ARM. Busy=1, ShortFrame cleared.
  - Start while Busy is ignored.
- ARM:
  - Waits for a CamVsync rising edge -> CAPTURE.
  - On entry: col=0, row=0, line base=0.
- CAPTURE, per pixel (CamHref & CamPixValid):
  - If col < H_ACTIVE: RamWE=1 for one cycle, RamWAddr = line base + col, RamDIn=CamPix, col++.
  - If col >= H_ACTIVE: pixel dropped, no write.
  - Write is registered: it appears 1 cycle after the strobe.
- CAPTURE, HREF falling edge: row++, col=0, line base += H_ACTIVE. No multiplier is used.
  - Short lines are not padded; RAM keeps its old content for the missing pixels.
- CAPTURE exits:
  - Row reaches V_ACTIVE -> DONE. Any further pixels are ignored.
  - CamVsync rising edge with row < V_ACTIVE -> DONE, ShortFrame=1.
  - Both in the same cycle: the row condition wins and ShortFrame is not set.
- DONE: FrameDone=1 for one cycle, Busy=0 -> IDLE.
- Read path (independent of state; always served, including during capture):
  - Cycle 0: RdReq sampled.
  - Cycle 1: RamRAddr = RdY*H_ACTIVE + RdX, registered.
  - Cycle 2: RdValid=1, RdData=RamDOut.
  - Back-to-back requests are fully pipelined, one per cycle.
  - RdX >= H_ACTIVE or RdY >= V_ACTIVE: RdValid still asserted at cycle 2 with RdData forced to 0. RamRAddr holds its previous value.
  - Reading a pixel in the same cycle it is written returns the old RAM content.

Optional Feature:
- Macro: OV7670_FB_CONTINUOUS_EN.
- Defined: DONE returns to ARM instead of IDLE. Busy stays 1 and every frame is captured until Start is pulsed again, which stops capture after the current frame. FrameDone still pulses once per frame.
- Undefined: single-shot behaviour exactly as specified above.

Test Plan:
- Reset, then Start, then VSYNC pulse, then 480 lines of 640 pixels (pixel = (x^y)&1) -> FrameDone once, ShortFrame=0, exactly 307200 writes. Last write is at address 307199; the last line begins at address 306560 (479*640).
- 700 pixel strobes in one HREF line -> only 640 writes. The next line starts at address 640.
- VSYNC rises after 100 lines -> FrameDone pulse, ShortFrame=1, Busy=0, no writes afterwards.
- After the full frame, RdReq at (X=5,Y=3) then (X=639,Y=479) on consecutive cycles -> RamRAddr 1925 then 307199. RdValid on cycles 2 and 3 with the matching data. RdX=640 -> RdValid=1, RdData=0.
- Reset asserted mid-line during CAPTURE -> RamWE=0 in the same cycle, Busy=0. Start plus a new frame afterwards captures from address 0.
- Start pulsed while Busy -> ignored; frame completes normally with a single FrameDone.
